// File: rtl/spi_word_slave.sv
// SPI slave front-end: oversampled pins, all CPOL/CPHA modes, word-wide rx pulses
// and a one-entry ready/valid transmit buffer feeding MISO.
module spi_word_slave #(
    parameter int WORD_WIDTH  = 32,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SPI_clock,
    input  logic                  SPI_not_chip_select,
    input  logic                  SPI_in,
    output logic                  SPI_out,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int CW = $clog2(WORD_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, settle;
    logic                   sclk_s, cs_s, mosi_s, sclk_prev, cs_prev, armed;
    logic                   lead, trail, sample_ev, shift_ev, frame_start, frame_end, do_load;
    logic [WORD_WIDTH-1:0]  shift_rx, shift_tx, tx_buf, rx_next;
    logic                   buf_full, load_pending;
    logic [CW-1:0]          cnt;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // settle keeps the select synchroniser's reset value from arming us: only
    // a select level that was really sampled after reset may arm a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            settle    <= '0;
            sclk_prev <= CPOL;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_clock};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_not_chip_select};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_in};
            settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            if (settle[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
        end
    end

    assign lead      = (sclk_prev == CPOL) && (sclk_s != CPOL);
    assign trail     = (sclk_prev != CPOL) && (sclk_s == CPOL);
    assign sample_ev = (state == ACTIVE) && !cs_s && (CPHA ? trail : lead);
    assign shift_ev  = (state == ACTIVE) && !cs_s && (CPHA ? lead : trail);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: if (armed && cs_prev && !cs_s) begin
                state_nx    = ACTIVE;
                frame_start = 1'b1;
            end
            ACTIVE: if (cs_s) begin
                state_nx  = IDLE;
                frame_end = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rx_next = shift_rx;
        if (MSB_FIRST) rx_next = {shift_rx[WORD_WIDTH-2:0], mosi_s};
        else           rx_next = {mosi_s, shift_rx[WORD_WIDTH-1:1]};
    end

    // CPHA=0 loads at frame start; every later word loads on its first shift edge.
    assign do_load = (frame_start && !CPHA) || (shift_ev && load_pending);

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_rx     <= '0;
            shift_tx     <= '0;
            tx_buf       <= '0;
            buf_full     <= 1'b0;
            load_pending <= 1'b0;
            cnt          <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (tx_valid && !buf_full) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end
            if (do_load) begin
                if (buf_full) begin
                    shift_tx <= tx_buf;
                    buf_full <= 1'b0;
                end else begin
                    shift_tx    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (shift_ev) begin
                shift_tx <= MSB_FIRST ? (shift_tx << 1) : (shift_tx >> 1);
            end
            if (frame_start)
                load_pending <= CPHA;
            else if (shift_ev && load_pending)
                load_pending <= 1'b0;
            else if (sample_ev && cnt == CW'(WORD_WIDTH-1))
                load_pending <= 1'b1;
            if (frame_start || frame_end)
                cnt <= '0;
            if (sample_ev) begin
                shift_rx <= rx_next;
                if (cnt == CW'(WORD_WIDTH-1)) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign SPI_out  = (state == ACTIVE) && (MSB_FIRST ? shift_tx[WORD_WIDTH-1] : shift_tx[0]);
    assign tx_ready = !buf_full;
    assign busy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_word_slave.sv
// Directed bench for spi_word_slave: three parameterisations driven by a
// bit-banged SPI master with hand-computed expected words.
`timescale 1ns/1ps
module tb_spi_word_slave;
    localparam int HALF = 60;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  sclk, cs, miso, rx_valid, tx_valid, tx_ready, tx_underrun, busy;
    logic        mosi;
    logic [31:0] tx_data;
    logic [31:0] rx0;
    logic [15:0] rx1;
    logic [7:0]  rx2;
    int          n_tests = 0, n_fail = 0;
    int          rxv[3] = '{0, 0, 0};
    int          urn[3] = '{0, 0, 0};

    always #5 clock = ~clock;

    spi_word_slave dut0 (
        .clock(clock), .reset(reset), .SPI_clock(sclk[0]), .SPI_not_chip_select(cs[0]),
        .SPI_in(mosi), .SPI_out(miso[0]), .rx_data(rx0), .rx_valid(rx_valid[0]),
        .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_underrun(tx_underrun[0]), .busy(busy[0]));

    spi_word_slave #(.WORD_WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clock(clock), .reset(reset), .SPI_clock(sclk[1]), .SPI_not_chip_select(cs[1]),
        .SPI_in(mosi), .SPI_out(miso[1]), .rx_data(rx1), .rx_valid(rx_valid[1]),
        .tx_data(tx_data[15:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_underrun(tx_underrun[1]), .busy(busy[1]));

    spi_word_slave #(.WORD_WIDTH(8), .MSB_FIRST(1'b0)) dut2 (
        .clock(clock), .reset(reset), .SPI_clock(sclk[2]), .SPI_not_chip_select(cs[2]),
        .SPI_in(mosi), .SPI_out(miso[2]), .rx_data(rx2), .rx_valid(rx_valid[2]),
        .tx_data(tx_data[7:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx_underrun(tx_underrun[2]), .busy(busy[2]));

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            rxv[i] <= rxv[i] + int'(rx_valid[i]);
            urn[i] <= urn[i] + int'(tx_underrun[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tx_write(input int d, input logic [31:0] v);
        int k = 0;
        while (!tx_ready[d] && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("tx_ready_wait", 32'(tx_ready[d]), 32'd1);
        @(negedge clock);
        tx_data     = v;
        tx_valid[d] = 1'b1;
        @(negedge clock);
        tx_valid[d] = 1'b0;
    endtask

    task automatic frame_begin(input int d);
        cs[d] = 1'b0;
        #HALF;
    endtask

    // Select rises before SCLK returns to idle, so a mode-0 frame never shows
    // the shift edge that would pull a further word out of the buffer.
    task automatic frame_end(input int d, input bit cpol);
        cs[d] = 1'b1;
        #HALF;
        sclk[d] = cpol;
        #HALF;
    endtask

    task automatic xfer(input int d, input int w, input int nbits, input bit cpol,
                        input bit cpha, input bit msb, input logic [31:0] data,
                        output logic [31:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            int pos;
            pos = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                if (sclk[d] != cpol) sclk[d] = cpol;
                mosi = data[pos];
                #HALF;
                got[pos] = miso[d];
                sclk[d] = ~cpol;
                #HALF;
            end else begin
                sclk[d] = ~cpol;
                mosi = data[pos];
                #HALF;
                got[pos] = miso[d];
                sclk[d] = cpol;
                #HALF;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] g, g1, g2;
        int r0, u0;
        reset = 1'b1; cs = 3'b111; sclk = 3'b010; mosi = 1'b0;
        tx_valid = 3'b000; tx_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_rx_data0", rx0, 32'h0);
        chk("rst_rx_data1", 32'(rx1), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_tx_ready", 32'(tx_ready), 32'h7);
        chk("rst_underrun", 32'(tx_underrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_miso", 32'(miso), 32'h0);
        repeat (10) @(negedge clock);

        // mode 0, 32-bit
        tx_write(0, 32'h40490FDB);
        chk("t1_buf_full", 32'(tx_ready[0]), 32'd0);
        r0 = rxv[0]; u0 = urn[0];
        frame_begin(0);
        chk("t1_busy", 32'(busy[0]), 32'd1);
        chk("t1_tx_ready_after_load", 32'(tx_ready[0]), 32'd1);
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'h3F800000, g);
        frame_end(0, 1'b0);
        chk("t1_rx_data", rx0, 32'h3F800000);
        chk("t1_rx_pulses", 32'(rxv[0] - r0), 32'd1);
        chk("t1_miso", g, 32'h40490FDB);
        chk("t1_underrun", 32'(urn[0] - u0), 32'd0);
        chk("t1_idle_miso", 32'(miso[0]), 32'd0);
        chk("t1_idle_busy", 32'(busy[0]), 32'd0);

        // mode 3, 16-bit
        tx_write(1, 32'h1234);
        frame_begin(1);
        xfer(1, 16, 16, 1'b1, 1'b1, 1'b1, 32'hBEEF, g);
        frame_end(1, 1'b1);
        chk("t2_rx_data", 32'(rx1), 32'hBEEF);
        chk("t2_miso", g, 32'h1234);
        chk("t2_rx_pulses", 32'(rxv[1]), 32'd1);

        // mode 0, 8-bit, LSB first
        tx_write(2, 32'h3C);
        frame_begin(2);
        xfer(2, 8, 8, 1'b0, 1'b0, 1'b0, 32'hA5, g);
        frame_end(2, 1'b0);
        chk("t3_rx_data", 32'(rx2), 32'hA5);
        chk("t3_miso", g, 32'h3C);
        chk("t3_rx_pulses", 32'(rxv[2]), 32'd1);

        // abort after 13 bits, then a full word
        r0 = rxv[0];
        frame_begin(0);
        xfer(0, 32, 13, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, g);
        frame_end(0, 1'b0);
        chk("t4_abort_no_pulse", 32'(rxv[0] - r0), 32'd0);
        chk("t4_abort_rx_hold", rx0, 32'h3F800000);
        frame_begin(0);
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'h00000001, g);
        frame_end(0, 1'b0);
        chk("t4_rx_data", rx0, 32'h00000001);
        chk("t4_rx_pulses", 32'(rxv[0] - r0), 32'd1);

        // two words in one frame, buffer refilled between them
        tx_write(0, 32'hA5A5A5A5);
        r0 = rxv[0]; u0 = urn[0];
        frame_begin(0);
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'h11111111, g1);
        chk("t5_rx_word1", rx0, 32'h11111111);
        tx_write(0, 32'h5A5A5A5A);
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'h22222222, g2);
        frame_end(0, 1'b0);
        chk("t5_rx_word2", rx0, 32'h22222222);
        chk("t5_rx_pulses", 32'(rxv[0] - r0), 32'd2);
        chk("t5_miso1", g1, 32'hA5A5A5A5);
        chk("t5_miso2", g2, 32'h5A5A5A5A);
        chk("t5_underrun", 32'(urn[0] - u0), 32'd0);

        // same without refill: second word underruns
        tx_write(0, 32'hA5A5A5A5);
        r0 = rxv[0]; u0 = urn[0];
        frame_begin(0);
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'h11111111, g1);
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'h22222222, g2);
        frame_end(0, 1'b0);
        chk("t6_rx_pulses", 32'(rxv[0] - r0), 32'd2);
        chk("t6_miso1", g1, 32'hA5A5A5A5);
        chk("t6_miso2", g2, 32'h0);
        chk("t6_underrun", 32'(urn[0] - u0), 32'd1);

        // reset mid-frame with select held low
        r0 = rxv[0];
        frame_begin(0);
        xfer(0, 32, 5, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, g);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'h12345678, g);
        chk("t7_no_pulse", 32'(rxv[0] - r0), 32'd0);
        chk("t7_busy", 32'(busy[0]), 32'd0);
        chk("t7_rx_reset", rx0, 32'h0);
        frame_end(0, 1'b0);
        frame_begin(0);
        xfer(0, 32, 32, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, g);
        frame_end(0, 1'b0);
        chk("t7_rx_data", rx0, 32'hCAFEF00D);
        chk("t7_rx_pulses", 32'(rxv[0] - r0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_word_slave.md
Name: spi_word_slave

Overview:
- Parametrised SPI slave front-end; successor to the fixed 1-bit serial port on spi_fpu.
- Oversamples SPI pins on the system clock and supports all four CPOL/CPHA modes, configurable word width and bit order.
- Delivers received words to the FPU datapath as single-cycle pulses and serialises result words from a one-entry ready/valid transmit buffer.
- Sits between the top-level pin wrapper and the FPU core.

Parameters:
- WORD_WIDTH, 32, bits per SPI word (≥4).
- CPOL, 0, idle level of SPI_clock.
- CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB first on both directions; 0 = LSB first.
- SYNC_STAGES, 2, synchroniser depth for SPI_clock, SPI_not_chip_select and SPI_in (≥2).

Ports:
- clock  in  1  system clock; must be ≥4× SPI_clock frequency.
- reset  in  1  synchronous, active-high reset.
- SPI_clock  in  1  raw SPI clock.
- SPI_not_chip_select  in  1  raw active-low select.
- SPI_in  in  1  raw MOSI.
- SPI_out  out  1  MISO.
- rx_data  out  WORD_WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  WORD_WIDTH  word to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  transmit buffer empty.
- tx_underrun  out  1  one-cycle pulse when a word starts with the buffer empty.
- busy  out  1  frame active (synchronised select low and armed).

Behaviour:
- Design has one clock and reset is synchronous, active-high.
- Reset values:
  - Synchronisers: SPI_clock = CPOL, select = 1, SPI_in = 0.
  - Outputs: rx_data = 0, rx_valid = 0, tx_ready = 1, tx_underrun = 0, busy = 0, SPI_out = 0.
  - Internal: tx buffer empty, bit counter = 0, armed = 0.
- Arming:
  - armed sets once synchronised select is seen high for ≥1 cycle.
  - Frames start only on a synchronised select falling edge while armed.
  - Reset released with select low therefore ignores the rest of that frame.
- States:
  - IDLE → ACTIVE on armed select falling edge.
  - ACTIVE → IDLE on synchronised select rising edge.
  - ACTIVE → IDLE on reset.
- Edge detection:
  - Compare synchronised SPI_clock with its previous value.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Only edges seen in ACTIVE have effect.
- Word load:
  - Occurs at frame start (CPHA=0) or at the first shift edge of each word (CPHA=1).
  - Also occurs at the first shift edge after each completed word (CPHA=0, back-to-back words).
  - Buffer full: shift_tx ← buffer, buffer becomes empty.
  - Buffer empty: shift_tx ← 0 and tx_underrun pulses that cycle.
  - SPI_out drives the selected end bit of shift_tx right after load (CPHA=0) or on the shift edge (CPHA=1).
- Sample edge:
  - Shift synchronised SPI_in into shift_rx at the MSB_FIRST-selected end; counter increments.
  - When counter == WORD_WIDTH-1: rx_data ← completed word, rx_valid = 1 for exactly the next cycle, counter wraps to 0.
  - A frame may carry any number of words.
- Shift edge (other than a load edge): advance shift_tx by one bit.
- Latency: rx_valid is high in the cycle following SYNC_STAGES+1 clock edges after the final raw sample edge is first captured.
- Abort: select rising mid-word discards the partial word. Counter is cleared, no rx_valid, and the tx buffer is untouched if not yet loaded.
- SPI_out is 0 whenever not ACTIVE.
- TX handshake:
  - tx_ready = buffer empty (registered).
  - Write on tx_valid && tx_ready.
  - If a load and a write coincide, only the load occurs; tx_ready was 0.
  - tx_data is ignored while tx_ready is 0.
- rx has no backpressure; rx_data holds until the next completed word.

Test Plan:
- Default params, buffer preloaded 0x40490FDB, send 0x3F800000 in mode 0 → rx_data = 0x3F800000, one rx_valid pulse; MISO carries 0x40490FDB MSB-first; tx_ready returns to 1 after frame start.
- CPOL=1, CPHA=1, WORD_WIDTH=16, send 0xBEEF with buffer 0x1234 → rx_data = 0xBEEF; MISO = 0x1234.
- MSB_FIRST=0, WORD_WIDTH=8, send 0xA5 LSB-first → rx_data = 0xA5; MISO reproduces buffer 0x3C LSB-first.
- Default params, abort after 13 bits, then full word 0x00000001 → no rx_valid for the abort; next rx_valid has 0x00000001.
- Two words 0x11111111, 0x22222222 in one select frame with buffer refilled once in between → two rx_valid pulses with those values; second tx word correct; tx_underrun = 0 throughout. Repeat without refill → tx_underrun pulses once and second MISO word is 0.
- Assert reset mid-frame while select stays low, continue clocking 32 bits → no rx_valid, busy = 0; after select high then low, 0xCAFEF00D is received correctly.
